exp5_unidade_controle: RTL and testbench
========================================

EXP5_UNIDADE_CONTROLE -- requirements
Module: exp5_unidade_controle

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000, idle clock cycles in ESPERA before timeout.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces INICIAL immediately.
REQ-004 iniciar  input  1  level, starts or restarts a game.
REQ-005 jogada  input  1  one-cycle pulse from datapath edge detector: player pressed a key.
REQ-006 igual  input  1  datapath comparator: registered play equals memory word.
REQ-007 enderecoIgualRodada  input  1  play address counter equals current round counter.
REQ-008 fimRod  input  1  round counter at last round (15).
REQ-009 zeraC, contaC  output  1 each  clear / increment play address counter.
REQ-010 zeraR, registraR  output  1 each  clear / load play register.
REQ-011 zeraRod, contaRod  output  1 each  clear / increment round counter.
REQ-012 acertou, errou, pronto  output  1 each  game result flags.
REQ-013 db_timeout  output  1  game ended by timeout.
REQ-014 db_estado  output  4  current state code, for hexa7seg display.

Function
REQ-015 Moore FSM; all outputs decoded from state only, no input-to-output paths.
REQ-016 States/codes: INICIAL 0, PREPARA 1, INICIA_RODADA 2, ESPERA 3, REGISTRA 4, COMPARA 5, PROX_JOGADA 6, PROX_RODADA 7, FIM_TIMEOUT C, FIM_ACERTO A, FIM_ERRO E; unused codes go to INICIAL next cycle.
REQ-017 INICIAL: all outputs 0; iniciar=1 -> PREPARA, else stay.
REQ-018 PREPARA: zeraC=zeraR=zeraRod=1; -> INICIA_RODADA.
REQ-019 INICIA_RODADA: zeraC=1; -> ESPERA.
REQ-020 ESPERA: jogada=1 -> REGISTRA; else timeout -> FIM_TIMEOUT; else stay; jogada wins over simultaneous timeout.
REQ-021 REGISTRA: registraR=1; -> COMPARA (igual valid one cycle after load).
REQ-022 COMPARA: igual=0 -> FIM_ERRO; igual=1 and enderecoIgualRodada=0 -> PROX_JOGADA; igual=1, enderecoIgualRodada=1, fimRod=0 -> PROX_RODADA; all three 1 -> FIM_ACERTO.
REQ-023 PROX_JOGADA: contaC=1; -> ESPERA. PROX_RODADA: contaRod=1; -> INICIA_RODADA.
REQ-024 Terminal states: pronto=1; FIM_ACERTO acertou=1; FIM_ERRO errou=1; FIM_TIMEOUT errou=1, db_timeout=1; iniciar=1 -> PREPARA, else hold.
REQ-025 Timer: width ceil(log2(TIMEOUT_CYCLES)), cleared in every state except ESPERA, increments each ESPERA cycle; timeout asserted when count = TIMEOUT_CYCLES-1; never wraps.
REQ-026 jogada pulses outside ESPERA are ignored; iniciar outside INICIAL/terminal states is ignored.
REQ-027 Latency: jogada in ESPERA -> registraR next cycle -> decision in COMPARA the cycle after.

Reset
REQ-028 reset=1 at any time, including mid-round: state INICIAL, timer 0, every output 0, db_estado 0, within the same cycle (asynchronous).
REQ-029 Release of reset takes effect at the next rising clock edge; no spurious control pulse on release.

Configuration
REQ-030 Macro TIMEOUT_EN: when defined, timer and FIM_TIMEOUT per REQ-020/025; when undefined, no timer logic, ESPERA waits indefinitely, FIM_TIMEOUT unreachable, db_timeout tied 0.

Structure
REQ-031 Shared package exp5_pkg holds the 4-bit state code constants and the TIMEOUT_CYCLES default, also used by top-level and bench.
REQ-032 Timer is one sub-module, contador_timeout (parameter M, inputs clock/reset/zera/conta, output fim), instantiated only under TIMEOUT_EN.

Verification
REQ-033 Reset asserted in ESPERA of round 3 -> db_estado 0 same cycle, all outputs 0; iniciar then -> PREPARA with zeraC/zeraR/zeraRod=1 one cycle.
REQ-034 Full game, 16 rounds, every play igual=1 -> FIM_ACERTO, acertou=1, pronto=1, exactly 15 contaRod pulses and 120 contaC pulses.
REQ-035 Round 2, second play igual=0 -> FIM_ERRO (db_estado E), errou=1, acertou=0, pronto=1.
REQ-036 TIMEOUT_CYCLES=10, no jogada in ESPERA -> FIM_TIMEOUT after exactly 10 ESPERA cycles, db_timeout=1, errou=1; with TIMEOUT_EN undefined -> stays in ESPERA after 1000 cycles.
REQ-037 jogada and timeout in same cycle -> REGISTRA, registraR=1 next cycle; jogada pulse during COMPARA -> ignored.
REQ-038 iniciar=1 in FIM_ERRO -> PREPARA next cycle, flags cleared, round counter cleared.

Source files
------------

// File: rtl/exp5_pkg.sv
// Shared definitions for the game control unit: state codes, output bundle
// and default timeout. Optional timeout support is selected with TIMEOUT_EN.
package exp5_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIA_RODADA = 4'h2,
    ESPERA        = 4'h3,
    REGISTRA      = 4'h4,
    COMPARA       = 4'h5,
    PROX_JOGADA   = 4'h6,
    PROX_RODADA   = 4'h7,
    FIM_ACERTO    = 4'hA,
    FIM_TIMEOUT   = 4'hC,
    FIM_ERRO      = 4'hE
  } estado_t;

  typedef struct packed {
    logic zeraC;
    logic contaC;
    logic zeraR;
    logic registraR;
    logic zeraRod;
    logic contaRod;
    logic acertou;
    logic errou;
    logic pronto;
    logic db_timeout;
  } ctrl_t;

  // Moore output decode; applied to the next state so outputs come out registered.
  function automatic ctrl_t decode(input estado_t s);
    ctrl_t c;
    c = '0;
    case (s)
      PREPARA: begin
        c.zeraC   = 1'b1;
        c.zeraR   = 1'b1;
        c.zeraRod = 1'b1;
      end
      INICIA_RODADA: c.zeraC     = 1'b1;
      REGISTRA:      c.registraR = 1'b1;
      PROX_JOGADA:   c.contaC    = 1'b1;
      PROX_RODADA:   c.contaRod  = 1'b1;
      FIM_ACERTO: begin
        c.acertou = 1'b1;
        c.pronto  = 1'b1;
      end
      FIM_ERRO: begin
        c.errou  = 1'b1;
        c.pronto = 1'b1;
      end
      FIM_TIMEOUT: begin
        c.errou  = 1'b1;
        c.pronto = 1'b1;
`ifdef TIMEOUT_EN
        c.db_timeout = 1'b1;
`endif
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Saturating idle-cycle timer for the control unit; only built with TIMEOUT_EN.
// fim rises when the count reaches M-1 and holds there until zera.
`ifdef TIMEOUT_EN
module contador_timeout #(
  parameter int M = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign fim = (cnt_q == W'(M - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (zera)
      cnt_d = '0;
    else if (conta && !fim)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/exp5_unidade_controle.sv
// Moore control unit for the memory game (rounds, plays, result flags).
// Define TIMEOUT_EN to enable the ESPERA idle timeout and FIM_TIMEOUT.
module exp5_unidade_controle
  import exp5_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       fimRod,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t estado_q, estado_d;
  ctrl_t   ctrl_q;
  logic    timeout;

`ifdef TIMEOUT_EN
  contador_timeout #(
    .M(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .zera (estado_q != ESPERA),
    .conta(estado_q == ESPERA),
    .fim  (timeout)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:       if (iniciar) estado_d = PREPARA;
      PREPARA:       estado_d = INICIA_RODADA;
      INICIA_RODADA: estado_d = ESPERA;
      ESPERA: begin
        if (jogada)
          estado_d = REGISTRA;
        else if (timeout)
          estado_d = FIM_TIMEOUT;
      end
      REGISTRA:      estado_d = COMPARA;
      COMPARA: begin
        if (!igual)
          estado_d = FIM_ERRO;
        else if (!enderecoIgualRodada)
          estado_d = PROX_JOGADA;
        else if (!fimRod)
          estado_d = PROX_RODADA;
        else
          estado_d = FIM_ACERTO;
      end
      PROX_JOGADA:   estado_d = ESPERA;
      PROX_RODADA:   estado_d = INICIA_RODADA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) estado_d = PREPARA;
      default:       estado_d = INICIAL;
    endcase
  end

  // Outputs are registered from the decoded next state, so they track estado_q exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
      ctrl_q   <= '0;
    end else begin
      estado_q <= estado_d;
      ctrl_q   <= decode(estado_d);
    end
  end

  assign zeraC      = ctrl_q.zeraC;
  assign contaC     = ctrl_q.contaC;
  assign zeraR      = ctrl_q.zeraR;
  assign registraR  = ctrl_q.registraR;
  assign zeraRod    = ctrl_q.zeraRod;
  assign contaRod   = ctrl_q.contaRod;
  assign acertou    = ctrl_q.acertou;
  assign errou      = ctrl_q.errou;
  assign pronto     = ctrl_q.pronto;
  assign db_timeout = ctrl_q.db_timeout;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Directed bench for exp5_unidade_controle with a small datapath model
// (play address and round counters) answering the control outputs.
module tb_exp5_unidade_controle;
  import exp5_pkg::*;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada, igual;
  logic       enderecoIgualRodada, fimRod;
  logic       zeraC, contaC, zeraR, registraR, zeraRod, contaRod;
  logic       acertou, errou, pronto, db_timeout;
  logic [3:0] db_estado;
  logic [13:0] obs;

  logic [3:0] addr = '0, rod = '0;
  int n_contaC = 0, n_contaRod = 0;
  int vectors = 0, miscompares = 0;

  // {state, zeraC contaC zeraR registraR zeraRod contaRod acertou errou pronto db_timeout}
  localparam logic [13:0] S_INICIAL  = {4'h0, 10'b0000000000};
  localparam logic [13:0] S_PREPARA  = {4'h1, 10'b1010100000};
  localparam logic [13:0] S_INICIA   = {4'h2, 10'b1000000000};
  localparam logic [13:0] S_ESPERA   = {4'h3, 10'b0000000000};
  localparam logic [13:0] S_REGISTRA = {4'h4, 10'b0001000000};
  localparam logic [13:0] S_COMPARA  = {4'h5, 10'b0000000000};
  localparam logic [13:0] S_PROX_JOG = {4'h6, 10'b0100000000};
  localparam logic [13:0] S_PROX_ROD = {4'h7, 10'b0000010000};
  localparam logic [13:0] S_ACERTO   = {4'hA, 10'b0000001010};
  localparam logic [13:0] S_ERRO     = {4'hE, 10'b0000000110};
  localparam logic [13:0] S_TIMEOUT  = {4'hC, 10'b0000000111};

  always #5 clock = ~clock;

  exp5_unidade_controle #(.TIMEOUT_CYCLES(10)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .enderecoIgualRodada(enderecoIgualRodada), .fimRod(fimRod),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .zeraRod(zeraRod), .contaRod(contaRod), .acertou(acertou), .errou(errou),
    .pronto(pronto), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  assign obs = {db_estado, zeraC, contaC, zeraR, registraR, zeraRod, contaRod,
                acertou, errou, pronto, db_timeout};
  assign enderecoIgualRodada = (addr == rod);
  assign fimRod = (rod == 4'd15);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= '0;
      rod  <= '0;
    end else begin
      if (zeraC) addr <= '0; else if (contaC) addr <= addr + 4'd1;
      if (zeraRod) rod <= '0; else if (contaRod) rod <= rod + 4'd1;
      if (contaC) n_contaC <= n_contaC + 1;
      if (contaRod) n_contaRod <= n_contaRod + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Assumes ESPERA; leaves the FSM in the next ESPERA or a terminal state.
  task automatic play(input logic v);
    igual = v;
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++)
      if (db_estado == 4'h6 || db_estado == 4'h7 || db_estado == 4'h2) tick();
  endtask

  task automatic start_game();
    reset = 1'b1;
    #2 reset = 1'b0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0;
    tick(); tick();
    vectors++;
    if (obs !== S_INICIAL) begin
      miscompares++; $display("FAIL reset_hold got %h want %h", obs, S_INICIAL);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (obs !== S_INICIAL) begin
      miscompares++; $display("FAIL reset_release got %h want %h", obs, S_INICIAL);
    end
    jogada = 1'b1;
    repeat (3) tick();
    jogada = 1'b0;
    vectors++;
    if (obs !== S_INICIAL) begin
      miscompares++; $display("FAIL idle_ignores_jogada got %h want %h", obs, S_INICIAL);
    end
  endtask

  task automatic test_first_rounds();
    iniciar = 1'b1;
    tick();
    vectors++;
    if (obs !== S_PREPARA) begin
      miscompares++; $display("FAIL start_prepara got %h want %h", obs, S_PREPARA);
    end
    iniciar = 1'b0;
    tick();
    vectors++;
    if (obs !== S_INICIA) begin
      miscompares++; $display("FAIL start_inicia got %h want %h", obs, S_INICIA);
    end
    tick();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    vectors++;
    if (obs !== S_ESPERA) begin
      miscompares++; $display("FAIL espera_ignores_iniciar got %h want %h", obs, S_ESPERA);
    end
    igual = 1'b1; jogada = 1'b1;
    tick();
    jogada = 1'b0;
    vectors++;
    if (obs !== S_REGISTRA) begin
      miscompares++; $display("FAIL latency_registra got %h want %h", obs, S_REGISTRA);
    end
    tick();
    vectors++;
    if (obs !== S_COMPARA) begin
      miscompares++; $display("FAIL latency_compara got %h want %h", obs, S_COMPARA);
    end
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    vectors++;
    if (obs !== S_PROX_ROD) begin
      miscompares++; $display("FAIL round0_prox_rodada got %h want %h", obs, S_PROX_ROD);
    end
    tick(); tick();
    jogada = 1'b1; tick(); jogada = 1'b0; tick();
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    vectors++;
    if (obs !== S_PROX_JOG) begin
      miscompares++; $display("FAIL round1_prox_jogada got %h want %h", obs, S_PROX_JOG);
    end
    tick();
    vectors++;
    if (obs !== S_ESPERA) begin
      miscompares++; $display("FAIL compara_ignores_jogada got %h want %h", obs, S_ESPERA);
    end
  endtask

  task automatic test_reset_midgame();
    start_game();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p <= r; p++) play(1'b1);
    vectors++;
    if (rod !== 4'd3 || obs !== S_ESPERA) begin
      miscompares++; $display("FAIL reach_round3 got rod=%0d st=%h want rod=3 st=%h", rod, obs, S_ESPERA);
    end
    play(1'b1);
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== S_INICIAL) begin
      miscompares++; $display("FAIL async_reset got %h want %h", obs, S_INICIAL);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    vectors++;
    if (obs !== S_INICIAL) begin
      miscompares++; $display("FAIL release_no_pulse got %h want %h", obs, S_INICIAL);
    end
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    vectors++;
    if (obs !== S_PREPARA) begin
      miscompares++; $display("FAIL restart_prepara got %h want %h", obs, S_PREPARA);
    end
    tick();
    vectors++;
    if (obs !== S_INICIA) begin
      miscompares++; $display("FAIL prepara_one_cycle got %h want %h", obs, S_INICIA);
    end
  endtask

  task automatic test_full_game();
    int c0, r0;
    start_game();
    c0 = n_contaC;
    r0 = n_contaRod;
    for (int r = 0; r < 16; r++)
      for (int p = 0; p <= r; p++) play(1'b1);
    vectors++;
    if (obs !== S_ACERTO) begin
      miscompares++; $display("FAIL game_acerto got %h want %h", obs, S_ACERTO);
    end
    vectors++;
    if (n_contaRod - r0 !== 15) begin
      miscompares++; $display("FAIL contaRod_pulses got %0d want 15", n_contaRod - r0);
    end
    vectors++;
    if (n_contaC - c0 !== 120) begin
      miscompares++; $display("FAIL contaC_pulses got %0d want 120", n_contaC - c0);
    end
    jogada = 1'b1;
    tick(); tick();
    jogada = 1'b0;
    vectors++;
    if (obs !== S_ACERTO) begin
      miscompares++; $display("FAIL acerto_hold got %h want %h", obs, S_ACERTO);
    end
  endtask

  task automatic test_erro_restart();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    vectors++;
    if (obs !== S_PREPARA) begin
      miscompares++; $display("FAIL acerto_restart got %h want %h", obs, S_PREPARA);
    end
    tick(); tick();
    play(1'b1);
    play(1'b1); play(1'b1);
    play(1'b1);
    play(1'b0);
    vectors++;
    if (obs !== S_ERRO) begin
      miscompares++; $display("FAIL round2_erro got %h want %h", obs, S_ERRO);
    end
    tick();
    vectors++;
    if (obs !== S_ERRO) begin
      miscompares++; $display("FAIL erro_hold got %h want %h", obs, S_ERRO);
    end
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    vectors++;
    if (obs !== S_PREPARA) begin
      miscompares++; $display("FAIL erro_restart got %h want %h", obs, S_PREPARA);
    end
    tick();
    vectors++;
    if (obs !== S_INICIA || rod !== 4'd0) begin
      miscompares++; $display("FAIL restart_cleared got st=%h rod=%0d want st=%h rod=0", obs, rod, S_INICIA);
    end
  endtask

  task automatic test_timeout();
`ifdef TIMEOUT_EN
    start_game();
    repeat (9) tick();
    vectors++;
    if (obs !== S_ESPERA) begin
      miscompares++; $display("FAIL espera_cycle10 got %h want %h", obs, S_ESPERA);
    end
    tick();
    vectors++;
    if (obs !== S_TIMEOUT) begin
      miscompares++; $display("FAIL timeout_state got %h want %h", obs, S_TIMEOUT);
    end
    start_game();
    repeat (9) tick();
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    vectors++;
    if (obs !== S_REGISTRA) begin
      miscompares++; $display("FAIL jogada_beats_timeout got %h want %h", obs, S_REGISTRA);
    end
`else
    start_game();
    repeat (1000) tick();
    vectors++;
    if (obs !== S_ESPERA) begin
      miscompares++; $display("FAIL no_timeout_wait got %h want %h", obs, S_ESPERA);
    end
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    vectors++;
    if (obs !== S_REGISTRA) begin
      miscompares++; $display("FAIL late_jogada got %h want %h", obs, S_REGISTRA);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_rounds();
    test_reset_midgame();
    test_full_game();
    test_erro_restart();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no_finish want finish");
    $fatal(1, "bench time limit expired");
  end

endmodule
